// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: per-axis timing record, standard presets, cfg bus field offsets and timing helpers
package vga_timing_pkg;
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;
  localparam int F_BP = 0;
  localparam int F_SYNC = 1;
  localparam int F_FP = 2;
  localparam int F_ACTIVE = 3;
  localparam timing_t H_640X480 = '{640, 16, 96, 48};
  localparam timing_t V_640X480 = '{480, 10, 2, 33};
  localparam timing_t H_800X600 = '{800, 40, 128, 88};
  localparam timing_t V_800X600 = '{600, 1, 4, 23};
  localparam timing_t H_1024X768 = '{1024, 24, 136, 160};
  localparam timing_t V_1024X768 = '{768, 3, 6, 29};
  function automatic int unsigned total(input timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
  function automatic int unsigned sync_start(input timing_t t);
    return t.active + t.fp;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel enable in, sync/pixel/strobe outputs; cfg reload bus only with VGA_TIMING_RELOAD_EN
interface vga_timing_gen_if #(
  parameter int CW = 12,
  parameter int FRAME_W = 16
);
  logic pix_en, hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x, y;
  logic [FRAME_W-1:0] frame_cnt;
`ifdef VGA_TIMING_RELOAD_EN
  logic cfg_valid, cfg_ready, cfg_err;
  logic [4*CW-1:0] cfg_h, cfg_v;
  modport master (
    input  pix_en, cfg_valid, cfg_h, cfg_v,
    output hsync, vsync, de, x, y, line_start, frame_start, frame_cnt, cfg_ready, cfg_err
  );
  modport slave (
    output pix_en, cfg_valid, cfg_h, cfg_v,
    input  hsync, vsync, de, x, y, line_start, frame_start, frame_cnt, cfg_ready, cfg_err
  );
`else
  modport master (
    input  pix_en,
    output hsync, vsync, de, x, y, line_start, frame_start, frame_cnt
  );
  modport slave (
    output pix_en,
    input  hsync, vsync, de, x, y, line_start, frame_start, frame_cnt
  );
`endif
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis counter wrapping at active+fp+sync+bp, with active/sync window decode
module vga_axis_counter #(
  parameter int CW = 12
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic [CW-1:0] active_i,
  input  logic [CW-1:0] fp_i,
  input  logic [CW-1:0] sync_i,
  input  logic [CW-1:0] bp_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          active_o,
  output logic          sync_o
);
  localparam int SW = CW + 2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] c, ss, tot;
  logic last;
  always_comb begin
    c = SW'(cnt_q);
    ss = SW'(active_i) + SW'(fp_i);
    tot = ss + SW'(sync_i) + SW'(bp_i);
    last = c >= tot - SW'(1);
    cnt_d = en_i ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
  end
  always_ff @(posedge clk_i)
    cnt_q <= !rst_n_i ? '0 : cnt_d;
  assign cnt_o = cnt_q;
  assign wrap_o = en_i && last;
  assign active_o = c < SW'(active_i);
  assign sync_o = c >= ss && c < ss + SW'(sync_i);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered raster timing generator; define VGA_TIMING_RELOAD_EN for runtime timing reload
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = 12,
  parameter int H_ACTIVE = H_640X480.active,
  parameter int H_FP     = H_640X480.fp,
  parameter int H_SYNC   = H_640X480.sync,
  parameter int H_BP     = H_640X480.bp,
  parameter int V_ACTIVE = V_640X480.active,
  parameter int V_FP     = V_640X480.fp,
  parameter int V_SYNC   = V_640X480.sync,
  parameter int V_BP     = V_640X480.bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FRAME_W  = 16
) (
  input logic clk_pix,
  input logic rst_n,
  vga_timing_gen_if.master bus
);
  localparam logic [4*CW-1:0] H_CFG = {CW'(H_ACTIVE), CW'(H_FP), CW'(H_SYNC), CW'(H_BP)};
  localparam logic [4*CW-1:0] V_CFG = {CW'(V_ACTIVE), CW'(V_FP), CW'(V_SYNC), CW'(V_BP)};
  logic [4*CW-1:0] th, tv;
  logic [CW-1:0] h_cnt, v_cnt, x_q, x_d, y_q, y_d;
  logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  function automatic logic [CW-1:0] fld(input logic [4*CW-1:0] t, input int f);
    return t[f*CW +: CW];
  endfunction
`ifdef VGA_TIMING_RELOAD_EN
  logic [4*CW-1:0] th_q, tv_q, ph_q, pv_q;
  logic pend_q, err_q, take, cfg_bad;
  assign take = bus.cfg_valid && !pend_q;
  assign cfg_bad = fld(bus.cfg_h, F_ACTIVE) == '0 || fld(bus.cfg_h, F_SYNC) == '0 ||
                   fld(bus.cfg_v, F_ACTIVE) == '0 || fld(bus.cfg_v, F_SYNC) == '0;
  // pending timing swaps in only on the frame wrap so the running frame finishes unchanged
  always_ff @(posedge clk_pix)
    if (!rst_n) begin
      th_q <= H_CFG;
      tv_q <= V_CFG;
      ph_q <= '0;
      pv_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= take && cfg_bad;
      if (v_wrap && pend_q) begin
        th_q <= ph_q;
        tv_q <= pv_q;
        pend_q <= 1'b0;
      end else if (take && !cfg_bad) begin
        ph_q <= bus.cfg_h;
        pv_q <= bus.cfg_v;
        pend_q <= 1'b1;
      end
    end
  assign th = th_q;
  assign tv = tv_q;
  assign bus.cfg_ready = !pend_q;
  assign bus.cfg_err = err_q;
`else
  assign th = H_CFG;
  assign tv = V_CFG;
`endif
  vga_axis_counter #(.CW(CW)) u_h (
    .clk_i(clk_pix), .rst_n_i(rst_n), .en_i(bus.pix_en),
    .active_i(fld(th, F_ACTIVE)), .fp_i(fld(th, F_FP)), .sync_i(fld(th, F_SYNC)), .bp_i(fld(th, F_BP)),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync)
  );
  vga_axis_counter #(.CW(CW)) u_v (
    .clk_i(clk_pix), .rst_n_i(rst_n), .en_i(h_wrap),
    .active_i(fld(tv, F_ACTIVE)), .fp_i(fld(tv, F_FP)), .sync_i(fld(tv, F_SYNC)), .bp_i(fld(tv, F_BP)),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .active_o(v_act), .sync_o(v_sync)
  );
  always_comb begin
    hs_d = bus.pix_en ? (h_sync ? HS_POL : ~HS_POL) : hs_q;
    vs_d = bus.pix_en ? (v_sync ? VS_POL : ~VS_POL) : vs_q;
    de_d = bus.pix_en ? h_act && v_act : de_q;
    x_d = bus.pix_en ? (h_act && v_act ? h_cnt : '0) : x_q;
    y_d = bus.pix_en ? (h_act && v_act ? v_cnt : '0) : y_q;
    ls_d = bus.pix_en && h_cnt == '0;
    fs_d = ls_d && v_cnt == '0;
    fc_d = fc_q + FRAME_W'(fs_d);
  end
  always_ff @(posedge clk_pix)
    if (!rst_n) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      x_q <= x_d;
      y_q <= y_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      fc_q <= fc_d;
    end
  assign bus.hsync = hs_q;
  assign bus.vsync = vs_q;
  assign bus.de = de_q;
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.line_start = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_cnt = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 instance plus a small 14x8 instance, vector table and sequences
module tb_vga_timing_gen;
  import vga_timing_pkg::*;
  localparam timing_t TH = '{8, 2, 3, 1};
  localparam timing_t TV = '{4, 1, 2, 1};
  localparam int HT = total(TH);
  localparam int FT = total(TH) * total(TV);
  typedef struct {
    logic rst_n, pe, hs, vs, de;
    int x, y;
    logic ls, fs;
    int fc;
  } vec_t;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int n_chk = 0, n_fail = 0;
  int first_low, last_low, n_low, ls_prev, n_ls, n_fs, n_dbl, vs_prev, n_edge, fs_list[$];
  logic ls_last;
  vec_t vt[20];
  vga_timing_gen_if #(.CW(12), .FRAME_W(16)) ifa ();
  vga_timing_gen_if #(.CW(12), .FRAME_W(2)) ifb ();
  vga_timing_gen dut_a (.clk_pix(clk), .rst_n(rst_a), .bus(ifa));
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .FRAME_W(2)
  ) dut_b (.clk_pix(clk), .rst_n(rst_b), .bus(ifb));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic edge_b(input logic r, input logic pe);
    rst_b = r;
    ifb.pix_en = pe;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_b();
    edge_b(1'b0, 1'b1);
    rst_b = 1'b1;
  endtask
  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.pix_en = 1'b0;
    ifb.pix_en = 1'b0;
`ifdef VGA_TIMING_RELOAD_EN
    ifa.cfg_valid = 1'b0;
    ifb.cfg_valid = 1'b0;
    ifa.cfg_h = '0;
    ifa.cfg_v = '0;
    ifb.cfg_h = '0;
    ifb.cfg_v = '0;
`endif
    //        rst pe  hs vs de  x  y  ls fs fc
    vt[0]  = '{0, 1,  1, 1, 0,  0, 0, 0, 0, 0};
    vt[1]  = '{1, 1,  1, 1, 1,  0, 0, 1, 1, 1};
    vt[2]  = '{1, 0,  1, 1, 1,  0, 0, 0, 0, 1};
    vt[3]  = '{1, 1,  1, 1, 1,  1, 0, 0, 0, 1};
    vt[4]  = '{1, 1,  1, 1, 1,  2, 0, 0, 0, 1};
    vt[5]  = '{1, 1,  1, 1, 1,  3, 0, 0, 0, 1};
    vt[6]  = '{1, 1,  1, 1, 1,  4, 0, 0, 0, 1};
    vt[7]  = '{1, 1,  1, 1, 1,  5, 0, 0, 0, 1};
    vt[8]  = '{1, 1,  1, 1, 1,  6, 0, 0, 0, 1};
    vt[9]  = '{1, 1,  1, 1, 1,  7, 0, 0, 0, 1};
    vt[10] = '{1, 1,  1, 1, 0,  0, 0, 0, 0, 1};
    vt[11] = '{1, 1,  1, 1, 0,  0, 0, 0, 0, 1};
    vt[12] = '{1, 1,  0, 1, 0,  0, 0, 0, 0, 1};
    vt[13] = '{1, 1,  0, 1, 0,  0, 0, 0, 0, 1};
    vt[14] = '{1, 1,  0, 1, 0,  0, 0, 0, 0, 1};
    vt[15] = '{1, 1,  1, 1, 0,  0, 0, 0, 0, 1};
    vt[16] = '{1, 1,  1, 1, 1,  0, 1, 1, 0, 1};
    vt[17] = '{1, 0,  1, 1, 1,  0, 1, 0, 0, 1};
    vt[18] = '{0, 1,  1, 1, 0,  0, 0, 0, 0, 0};
    vt[19] = '{1, 1,  1, 1, 1,  0, 0, 1, 1, 1};
    // default 640x480 instance: one-line timing, then reset at (300,10)
    ifa.pix_en = 1'b1;
    @(posedge clk);
    #1;
    chk("a_rst_hsync", ifa.hsync, 1);
    chk("a_rst_fcnt", ifa.frame_cnt, 0);
    rst_a = 1'b1;
    first_low = -1; last_low = -1; n_low = 0; ls_prev = -1; n_ls = 0; n_fs = 0;
    for (int i = 0; i < 8300; i++) begin
      @(posedge clk);
      #1;
      if (i < 800 && !ifa.hsync) begin
        n_low++;
        if (first_low < 0) first_low = i;
        last_low = i;
      end
      if (ifa.line_start) begin
        if (ls_prev >= 0 && n_ls < 3) chk("a_line_period", i - ls_prev, total(H_640X480));
        ls_prev = i;
        n_ls++;
      end
      if (ifa.frame_start) n_fs++;
    end
    chk("a_hsync_first", first_low, 656);
    chk("a_hsync_last", last_low, 751);
    chk("a_hsync_width", n_low, 96);
    chk("a_line_count", n_ls, 11);
    chk("a_frame_count", n_fs, 1);
    @(posedge clk);
    #1;
    chk("a_x300", ifa.x, 300);
    chk("a_y10", ifa.y, 10);
    chk("a_de_mid", ifa.de, 1);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    chk("a_mrst_de", ifa.de, 0);
    chk("a_mrst_x", ifa.x, 0);
    chk("a_mrst_y", ifa.y, 0);
    chk("a_mrst_hs", ifa.hsync, 1);
    chk("a_mrst_vs", ifa.vsync, 1);
    chk("a_mrst_fc", ifa.frame_cnt, 0);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    chk("a_post_x", ifa.x, 0);
    chk("a_post_y", ifa.y, 0);
    chk("a_post_fs", ifa.frame_start, 1);
    chk("a_post_fc", ifa.frame_cnt, 1);
    ifa.pix_en = 1'b0;
    // small instance: vector table
    for (int i = 0; i < 20; i++) begin
      edge_b(vt[i].rst_n, vt[i].pe);
      chk($sformatf("v%0d_hs", i), ifb.hsync, vt[i].hs);
      chk($sformatf("v%0d_vs", i), ifb.vsync, vt[i].vs);
      chk($sformatf("v%0d_de", i), ifb.de, vt[i].de);
      chk($sformatf("v%0d_x", i), ifb.x, vt[i].x);
      chk($sformatf("v%0d_y", i), ifb.y, vt[i].y);
      chk($sformatf("v%0d_ls", i), ifb.line_start, vt[i].ls);
      chk($sformatf("v%0d_fs", i), ifb.frame_start, vt[i].fs);
      chk($sformatf("v%0d_fc", i), ifb.frame_cnt, vt[i].fc);
    end
    // pix_en on every other clock: line period doubles, strobes stay one clock wide
    reset_b();
    ls_prev = -1; n_ls = 0; n_dbl = 0; ls_last = 1'b0;
    for (int c = 0; c < 120; c++) begin
      edge_b(1'b1, (c % 2) == 0);
      if (ifb.line_start) begin
        if (ls_prev >= 0) chk("b_ls_period", c - ls_prev, 2 * HT);
        ls_prev = c;
        n_ls++;
        if (ls_last) n_dbl++;
      end
      ls_last = ifb.line_start;
    end
    chk("b_ls_count", n_ls, 5);
    chk("b_ls_wide", n_dbl, 0);
    // five frames: 2-bit frame_cnt wrap, vsync window and alignment with line_start
    reset_b();
    ls_prev = -1; n_fs = 0; n_low = 0; first_low = -1; n_edge = 0; vs_prev = 1;
    for (int i = 0; i < 5 * FT; i++) begin
      edge_b(1'b1, 1'b1);
      if (ifb.frame_start) begin
        chk($sformatf("b_fc%0d", n_fs), ifb.frame_cnt, (n_fs + 1) % 4);
        if (ls_prev >= 0) chk("b_frame_period", i - ls_prev, FT);
        ls_prev = i;
        n_fs++;
      end
      if (!ifb.vsync) begin
        n_low++;
        if (first_low < 0) first_low = i;
      end
      if (int'(ifb.vsync) != vs_prev) begin
        chk("b_vs_edge_ls", ifb.line_start, 1);
        n_edge++;
      end
      vs_prev = int'(ifb.vsync);
    end
    chk("b_frames", n_fs, 5);
    chk("b_vs_first", first_low, 70);
    chk("b_vs_low", n_low, 5 * 28);
    chk("b_vs_edges", n_edge, 10);
`ifdef VGA_TIMING_RELOAD_EN
    // reload accepted mid-frame takes effect at the next frame
    reset_b();
    fs_list.delete();
    for (int i = 0; i < 190; i++) begin
      ifb.cfg_valid = (i == 28);
      ifb.cfg_h = {12'd4, 12'd1, 12'd1, 12'd1};
      ifb.cfg_v = {12'd2, 12'd1, 12'd1, 12'd1};
      edge_b(1'b1, 1'b1);
      if (i == 27) chk("r_ready_idle", ifb.cfg_ready, 1);
      if (i == 28) chk("r_ready_busy", ifb.cfg_ready, 0);
      if (i == 110) chk("r_ready_hold", ifb.cfg_ready, 0);
      if (i == 111) chk("r_ready_back", ifb.cfg_ready, 1);
      if (i == 116) chk("r_new_de", ifb.de, 0);
      if (i == 119) chk("r_new_ls", ifb.line_start, 1);
      if (ifb.frame_start) fs_list.push_back(i);
    end
    ifb.cfg_valid = 1'b0;
    chk("r_fs_count", fs_list.size(), 4);
    if (fs_list.size() == 4) begin
      chk("r_fs1", fs_list[1], 112);
      chk("r_fs2", fs_list[2], 147);
      chk("r_fs3", fs_list[3], 182);
    end
    // zero sync width is rejected with a one-clock error
    reset_b();
    fs_list.delete();
    for (int i = 0; i < 130; i++) begin
      ifb.cfg_valid = (i == 5);
      ifb.cfg_h = {12'd4, 12'd1, 12'd0, 12'd1};
      ifb.cfg_v = {12'd2, 12'd1, 12'd1, 12'd1};
      edge_b(1'b1, 1'b1);
      if (i == 4) chk("e_err_idle", ifb.cfg_err, 0);
      if (i == 5) chk("e_err_pulse", ifb.cfg_err, 1);
      if (i == 5) chk("e_ready", ifb.cfg_ready, 1);
      if (i == 6) chk("e_err_clear", ifb.cfg_err, 0);
      if (ifb.frame_start) fs_list.push_back(i);
    end
    ifb.cfg_valid = 1'b0;
    chk("e_fs_count", fs_list.size(), 2);
    if (fs_list.size() == 2) chk("e_fs1", fs_list[1], FT);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
